// File: rtl/vga_pkg.sv
// Shared grid geometry defaults, cursor FSM encoding and direction helpers
// used by the cursor rectangle controller.
package vga_pkg;

    localparam int DEF_CELL_W   = 16;
    localparam int DEF_CELL_H   = 16;
    localparam int DEF_COLS     = 40;
    localparam int DEF_ROWS     = 30;
    localparam int DEF_ORIGIN_X = 0;
    localparam int DEF_ORIGIN_Y = 0;

    localparam int COL_W = 6;
    localparam int ROW_W = 5;
    localparam int POS_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } cursor_state_t;

    typedef logic signed [1:0] delta_t;

    localparam delta_t DELTA_ZERO = 2'b00;
    localparam delta_t DELTA_POS  = 2'b01;
    localparam delta_t DELTA_NEG  = 2'b11;

    typedef struct packed {
        delta_t dx;
        delta_t dy;
    } dir_t;

    // Opposing buttons cancel; a single pressed button gives +1 or -1.
    function automatic delta_t axis_delta(input logic pos, input logic neg);
        if (pos && !neg)
            return DELTA_POS;
        else if (neg && !pos)
            return DELTA_NEG;
        else
            return DELTA_ZERO;
    endfunction

endpackage

// File: rtl/cursor_axis_step.sv
// Next cell index along one axis for a -1/0/+1 step, wrapping or clamping
// at the grid edge.
module cursor_axis_step
    import vga_pkg::*;
#(
    parameter int W     = 6,
    parameter int LIMIT = 40,
    parameter bit WRAP  = 1'b1
) (
    input  logic [W-1:0] idx,
    input  delta_t       delta,
    output logic [W-1:0] next_idx
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    // NOTE: default first so every path assigns next_idx and no latch is inferred.
    always_comb begin
        next_idx = idx;
        if (delta == DELTA_POS) begin
            if (idx == LAST)
                next_idx = WRAP ? '0 : idx;
            else
                next_idx = idx + 1'b1;
        end else if (delta == DELTA_NEG) begin
            if (idx == '0)
                next_idx = WRAP ? LAST : idx;
            else
                next_idx = idx - 1'b1;
        end
    end

endmodule

// File: rtl/cursor_rect_ctrl.sv
// Frame-synchronous cursor positioning with hold-to-repeat and blink, driving
// the position/enable inputs of a downstream rectangle generator.
module cursor_rect_ctrl
    import vga_pkg::*;
#(
    parameter int CELL_W       = DEF_CELL_W,
    parameter int CELL_H       = DEF_CELL_H,
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int ORIGIN_X     = DEF_ORIGIN_X,
    parameter int ORIGIN_Y     = DEF_ORIGIN_Y,
    parameter bit WRAP         = 1'b1,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic [COL_W-1:0] cell_col,
    output logic [ROW_W-1:0] cell_row,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             cursor_enb,
    output logic             moved
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0]   DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]   RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    cursor_state_t      state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BLINK_W-1:0] blink_cnt;
    dir_t               dir, dir_latched;
    logic               step;
    logic               dir_zero;
    logic               pos_change;
    logic [COL_W-1:0]   col_nxt;
    logic [ROW_W-1:0]   row_nxt;

    assign dir.dx   = axis_delta(btn_right, btn_left);
    assign dir.dy   = axis_delta(btn_down, btn_up);
    assign dir_zero = (dir.dx == DELTA_ZERO) && (dir.dy == DELTA_ZERO);

    cursor_axis_step #(.W(COL_W), .LIMIT(COLS), .WRAP(WRAP)) u_col_step (
        .idx      (cell_col),
        .delta    (dir.dx),
        .next_idx (col_nxt)
    );

    cursor_axis_step #(.W(ROW_W), .LIMIT(ROWS), .WRAP(WRAP)) u_row_step (
        .idx      (cell_row),
        .delta    (dir.dy),
        .next_idx (row_nxt)
    );

    assign pos_change = (col_nxt != cell_col) || (row_nxt != cell_row);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step      = 1'b0;
        if (frame_tick) begin
            unique case (state)
                IDLE: begin
                    if (!dir_zero) begin
                        step      = 1'b1;
                        cnt_nxt   = DELAY_LOAD;
                        state_nxt = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (dir_zero) begin
                        state_nxt = IDLE;
                    end else if (dir != dir_latched) begin
                        // A new direction restarts the initial repeat delay.
                        step      = 1'b1;
                        cnt_nxt   = DELAY_LOAD;
                        state_nxt = HOLD;
                    end else if (cnt == '0) begin
                        step      = 1'b1;
                        cnt_nxt   = RATE_LOAD;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dir_latched <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (step)
                dir_latched <= dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_col   <= '0;
            cell_row   <= '0;
            moved      <= 1'b0;
            x_pos      <= POS_W'(ORIGIN_X);
            y_pos      <= POS_W'(ORIGIN_Y);
            blink_cnt  <= '0;
            cursor_enb <= 1'b1;
        end else begin
            moved <= step && pos_change;
            if (step) begin
                cell_col <= col_nxt;
                cell_row <= row_nxt;
            end
            // Pixel position trails the cell index by one cycle.
            x_pos <= POS_W'(ORIGIN_X) + POS_W'(cell_col) * POS_W'(CELL_W);
            y_pos <= POS_W'(ORIGIN_Y) + POS_W'(cell_row) * POS_W'(CELL_H);
            if (frame_tick) begin
                if (step && pos_change) begin
                    blink_cnt  <= '0;
                    cursor_enb <= 1'b1;
                end else if (blink_cnt == BLINK_LAST) begin
                    blink_cnt  <= '0;
                    cursor_enb <= ~cursor_enb;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cursor_rect_ctrl.sv
// Directed bench for cursor_rect_ctrl: one wrapping and one clamping
// instance share stimulus; expectations are hand-computed per scenario.
module tb_cursor_rect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;

    logic [5:0]  col_w, col_c;
    logic [4:0]  row_w, row_c;
    logic [10:0] x_w, x_c, y_w, y_c;
    logic        enb_w, enb_c, moved_w, moved_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cursor_rect_ctrl #(.WRAP(1'b1)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .cell_col   (col_w),
        .cell_row   (row_w),
        .x_pos      (x_w),
        .y_pos      (y_w),
        .cursor_enb (enb_w),
        .moved      (moved_w)
    );

    cursor_rect_ctrl #(.WRAP(1'b0)) dut_clamp (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .cell_col   (col_c),
        .cell_row   (row_c),
        .x_pos      (x_c),
        .y_pos      (y_c),
        .cursor_enb (enb_c),
        .moved      (moved_c)
    );

    // Returns on the falling edge right after the tick's rising edge, where
    // cell_col/row and moved reflect that tick and x/y_pos do not yet.
    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        frame_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (col_w !== 6'd0 || row_w !== 5'd0 || x_w !== 11'd0 || y_w !== 11'd0) begin
            failures++;
            $display("FAIL reset_pos got col=%0d row=%0d x=%0d y=%0d want 0 0 0 0", col_w, row_w, x_w, y_w);
        end
        checks++;
        if (enb_w !== 1'b1 || moved_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got enb=%b moved=%b want enb=1 moved=0", enb_w, moved_w);
        end
        for (int t = 1; t <= 5; t++) begin
            do_tick();
            checks++;
            if (moved_w !== 1'b0 || moved_c !== 1'b0) begin
                failures++;
                $display("FAIL idle_moved tick=%0d got %b/%b want 0/0", t, moved_w, moved_c);
            end
        end
        checks++;
        if (col_w !== 6'd0 || row_w !== 5'd0 || enb_w !== 1'b1) begin
            failures++;
            $display("FAIL idle_hold got col=%0d row=%0d enb=%b want 0 0 1", col_w, row_w, enb_w);
        end
    endtask

    task automatic test_single_step();
        apply_reset();
        btn_right = 1'b1;
        do_tick();
        btn_right = 1'b0;
        checks++;
        if (col_w !== 6'd1 || moved_w !== 1'b1 || x_w !== 11'd0) begin
            failures++;
            $display("FAIL step_right got col=%0d moved=%b x=%0d want 1 1 0", col_w, moved_w, x_w);
        end
        @(negedge clk);
        checks++;
        if (moved_w !== 1'b0 || x_w !== 11'd16) begin
            failures++;
            $display("FAIL step_right_x got moved=%b x=%0d want 0 16", moved_w, x_w);
        end
    endtask

    task automatic test_hold_repeat();
        int  exp_row;
        logic exp_step;
        apply_reset();
        btn_down = 1'b1;
        exp_row = 0;
        for (int t = 1; t <= 30; t++) begin
            do_tick();
            exp_step = (t == 1) || (t == 21) || (t == 25) || (t == 29);
            if (exp_step)
                exp_row++;
            checks++;
            if (row_w !== 5'(exp_row) || moved_w !== exp_step) begin
                failures++;
                $display("FAIL hold_repeat tick=%0d got row=%0d moved=%b want row=%0d moved=%b",
                         t, row_w, moved_w, exp_row, exp_step);
            end
        end
        btn_down = 1'b0;
        @(negedge clk);
        checks++;
        if (row_w !== 5'd4 || y_w !== 11'd64 || row_c !== 5'd4) begin
            failures++;
            $display("FAIL hold_final got row=%0d y=%0d row_clamp=%0d want 4 64 4", row_w, y_w, row_c);
        end
    endtask

    task automatic test_wrap_clamp();
        apply_reset();
        btn_left = 1'b1;
        do_tick();
        btn_left = 1'b0;
        checks++;
        if (col_w !== 6'd39 || moved_w !== 1'b1) begin
            failures++;
            $display("FAIL wrap_left got col=%0d moved=%b want 39 1", col_w, moved_w);
        end
        checks++;
        if (col_c !== 6'd0 || moved_c !== 1'b0) begin
            failures++;
            $display("FAIL clamp_left got col=%0d moved=%b want 0 0", col_c, moved_c);
        end
        @(negedge clk);
        checks++;
        if (x_w !== 11'd624 || x_c !== 11'd0 || moved_c !== 1'b0) begin
            failures++;
            $display("FAIL wrap_clamp_x got x_wrap=%0d x_clamp=%0d moved_clamp=%b want 624 0 0",
                     x_w, x_c, moved_c);
        end
    endtask

    task automatic test_opposing();
        apply_reset();
        {btn_left, btn_right, btn_up} = 3'b111;
        do_tick();
        checks++;
        if (row_w !== 5'd29 || col_w !== 6'd0 || moved_w !== 1'b1) begin
            failures++;
            $display("FAIL opposing_wrap got row=%0d col=%0d moved=%b want 29 0 1", row_w, col_w, moved_w);
        end
        checks++;
        if (row_c !== 5'd0 || col_c !== 6'd0 || moved_c !== 1'b0) begin
            failures++;
            $display("FAIL opposing_clamp got row=%0d col=%0d moved=%b want 0 0 0", row_c, col_c, moved_c);
        end
        repeat (2) do_tick();
        checks++;
        if (row_w !== 5'd29 || col_w !== 6'd0 || y_w !== 11'd464) begin
            failures++;
            $display("FAIL opposing_held got row=%0d col=%0d y=%0d want 29 0 464", row_w, col_w, y_w);
        end
        {btn_left, btn_right, btn_up} = 3'b000;
    endtask

    task automatic test_blink_and_reset();
        apply_reset();
        repeat (29) do_tick();
        checks++;
        if (enb_w !== 1'b1) begin
            failures++;
            $display("FAIL blink_before got enb=%b want 1", enb_w);
        end
        do_tick();
        checks++;
        if (enb_w !== 1'b0 || enb_c !== 1'b0) begin
            failures++;
            $display("FAIL blink_drop got enb=%b/%b want 0/0", enb_w, enb_c);
        end
        btn_up = 1'b1;
        do_tick();
        btn_up = 1'b0;
        checks++;
        if (enb_w !== 1'b1 || row_w !== 5'd29) begin
            failures++;
            $display("FAIL blink_force got enb=%b row=%0d want 1 29", enb_w, row_w);
        end
        // Counter cleared on the step: 29 more ticks keep enb high, the 30th drops it.
        repeat (29) do_tick();
        checks++;
        if (enb_w !== 1'b1) begin
            failures++;
            $display("FAIL blink_cleared got enb=%b want 1", enb_w);
        end
        do_tick();
        checks++;
        if (enb_w !== 1'b0) begin
            failures++;
            $display("FAIL blink_redrop got enb=%b want 0", enb_w);
        end
        btn_right = 1'b1;
        repeat (3) do_tick();
        checks++;
        if (col_w !== 6'd1 || x_w !== 11'd16) begin
            failures++;
            $display("FAIL hold_before_rst got col=%0d x=%0d want 1 16", col_w, x_w);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (col_w !== 6'd0 || row_w !== 5'd0 || x_w !== 11'd0 || y_w !== 11'd0 ||
            enb_w !== 1'b1 || moved_w !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got col=%0d row=%0d x=%0d y=%0d enb=%b moved=%b want 0 0 0 0 1 0",
                     col_w, row_w, x_w, y_w, enb_w, moved_w);
        end
        @(negedge clk) rst_n = 1'b1;
        do_tick();
        checks++;
        if (col_w !== 6'd1 || moved_w !== 1'b1) begin
            failures++;
            $display("FAIL fresh_press got col=%0d moved=%b want 1 1", col_w, moved_w);
        end
        btn_right = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_hold_repeat();
        test_wrap_clamp();
        test_opposing();
        test_blink_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
